// File: rtl/beam_pkg.sv
// Shared beamformer constants: default datapath widths and signed saturation limits.
package beam_pkg;

  localparam int unsigned BEAM_IN_W  = 23;
  localparam int unsigned BEAM_OUT_W = 16;

  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Flop-based synchronous FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  always_comb begin
    full    = (cnt_q == (AW + 1)'(DEPTH));
    empty   = (cnt_q == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    dout    = mem_q[rd_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/beam_decimator.sv
// Integrate-and-dump decimator for the beam sum with round half-up, saturation and
// an output FIFO; sticky flags report clipping and dropped results.
module beam_decimator
  import beam_pkg::*;
#(
  parameter int unsigned IN_W       = BEAM_IN_W,
  parameter int unsigned OUT_W      = BEAM_OUT_W,
  parameter int unsigned DECIM_LOG2 = 2,
  parameter int unsigned OUT_SHIFT  = 7,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  in_sum,
  input  logic                    in_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat,
  output logic                    ovf,
  input  logic                    clr_flags
);

  localparam int unsigned S     = DECIM_LOG2 + OUT_SHIFT;
  localparam int unsigned SUM_W = IN_W + DECIM_LOG2;
  localparam int unsigned RND_W = SUM_W + 1;
  localparam int unsigned PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

  localparam logic [PH_W-1:0]         PH_LAST = PH_W'((1 << DECIM_LOG2) - 1);
  localparam logic signed [RND_W-1:0] RND_OFS = RND_W'((S > 0) ? (64'd1 << (S - 1)) : 64'd0);
  localparam logic signed [RND_W-1:0] LIM_HI  = RND_W'(sat_max(OUT_W));
  localparam logic signed [RND_W-1:0] LIM_LO  = RND_W'(sat_min(OUT_W));

  logic signed [SUM_W-1:0] acc_q, sum;
  logic [PH_W-1:0]         phase_q;
  logic signed [RND_W-1:0] rnd, shifted;
  logic signed [OUT_W-1:0] res, push_data_q;
  logic                    clip, last, push_q;
  logic                    sat_q, ovf_q;
  logic                    full, empty, pop;

  always_comb begin
    sum     = acc_q + SUM_W'(in_sum);
    // One guard bit so the rounding offset cannot wrap the group sum.
    rnd     = RND_W'(sum) + RND_OFS;
    shifted = rnd >>> S;
    clip    = 1'b0;
    res     = shifted[OUT_W-1:0];
    if (shifted > LIM_HI) begin
      res  = LIM_HI[OUT_W-1:0];
      clip = 1'b1;
    end else if (shifted < LIM_LO) begin
      res  = LIM_LO[OUT_W-1:0];
      clip = 1'b1;
    end
    last      = (phase_q == PH_LAST);
    out_valid = ~empty;
    pop       = ~empty & out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      phase_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (in_valid) begin
        if (last) begin
          acc_q       <= '0;
          phase_q     <= '0;
          push_q      <= 1'b1;
          push_data_q <= res;
        end else begin
          acc_q   <= sum;
          phase_q <= phase_q + 1'b1;
        end
      end
      // Set events win over a simultaneous clear.
      sat_q <= (in_valid & last & clip) | (sat_q & ~clr_flags);
      ovf_q <= (push_q & full & ~pop) | (ovf_q & ~clr_flags);
    end
  end

  assign sat = sat_q;
  assign ovf = ovf_q;

  sync_fifo #(
    .WIDTH(OUT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_q),
    .din  (push_data_q),
    .pop  (pop),
    .dout (out_data),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_beam_decimator.sv
// Directed bench for beam_decimator at default parameters, plus a gapped random stream
// checked against a small integer reference.
module tb_beam_decimator;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [22:0] in_sum;
  logic               in_valid;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               sat;
  logic               ovf;
  logic               clr_flags;

  int checks;
  int failures;

  longint exp_q[$];
  longint acc;
  int     ph;

  always #5 clk = ~clk;

  beam_decimator dut (
    .clk      (clk),
    .rst      (rst),
    .in_sum   (in_sum),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sat      (sat),
    .ovf      (ovf),
    .clr_flags(clr_flags)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_sum   = 23'(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_group(input int v);
    repeat (4) send(v);
  endtask

  function automatic longint model(input longint sum);
    longint r;
    r = (sum + 256) >>> 9;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic check_pop();
    if (out_valid && out_ready) begin
      check("s6_expected_pending", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("s6_data", out_data, exp_q.pop_front());
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;
    clr_flags = 1'b0;
    repeat (2) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sat", sat, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    // Basic rounding: 4000 + 256 >> 9 = 8, visible two cycles after the 4th input.
    out_ready = 1'b1;
    send_group(1000);
    check("s1_not_early", out_valid, 0);
    tick();
    check("s1_valid", out_valid, 1);
    check("s1_data", out_data, 8);
    tick();
    check("s1_one_pulse", out_valid, 0);
    check("s1_sat", sat, 0);

    // Positive clip, then clear.
    send_group(4194303);
    tick();
    check("s2_valid", out_valid, 1);
    check("s2_data", out_data, 32767);
    check("s2_sat", sat, 1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("s2_sat_clr", sat, 0);

    // Negative boundary lands exactly on -32768 without clipping.
    send_group(-4194304);
    tick();
    check("s3_data", out_data, -32768);
    check("s3_sat", sat, 0);
    tick();

    // Overflow: five results into a depth-4 FIFO with no consumer.
    out_ready = 1'b0;
    repeat (5) send_group(512);
    repeat (3) tick();
    check("s4_ovf", ovf, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("s4_pop_valid", out_valid, 1);
      check("s4_pop_data", out_data, 4);
      tick();
    end
    check("s4_drained", out_valid, 0);

    // Reset mid-group discards the partial sum.
    send(10000);
    send(10000);
    rst = 1'b1;
    #2;
    check("s5_async_ovf", ovf, 0);
    check("s5_async_valid", out_valid, 0);
    tick();
    rst = 1'b0;
    send_group(512);
    tick();
    check("s5_valid", out_valid, 1);
    check("s5_data", out_data, 4);
    tick();
    check("s5_single", out_valid, 0);

    // Gapped inputs, random consumer.
    acc = 0;
    ph  = 0;
    for (int cyc = 0; cyc < 360; cyc++) begin
      in_valid = (cyc % 3 == 0);
      if (in_valid) begin
        int v;
        v      = int'($urandom_range(32'd8388607, 32'd0)) - 4194304;
        in_sum = 23'(v);
        acc    = acc + v;
        ph++;
        if (ph == 4) begin
          exp_q.push_back(model(acc));
          acc = 0;
          ph  = 0;
        end
      end
      out_ready = 1'($urandom_range(1, 0));
      check_pop();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_pop();
      tick();
    end
    check("s6_all_seen", exp_q.size(), 0);
    check("s6_no_ovf", ovf, 0);
    check("s6_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beam_decimator.md
BEAM_DECIMATOR -- requirements
Module: beam_decimator

Interface
REQ-001 SHALL have parameter IN_W, default 23, giving the width of the signed beam-sum input.
REQ-002 SHALL have parameter OUT_W, default 16, giving the width of the signed decimated output.
REQ-003 SHALL have parameter DECIM_LOG2, default 2, where the decimation ratio is 2^DECIM_LOG2 and the legal range is 0..6.
REQ-004 SHALL have parameter OUT_SHIFT, default 7, giving an extra gain right-shift applied after decimation.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO depth as a power of two.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port in_sum, input, IN_W bits: signed beam sum from the 16-channel adder tree.
REQ-009 SHALL have port in_valid, input, 1 bit: in_sum is valid this cycle; there is no backpressure on the input.
REQ-010 SHALL have port out_data, output, OUT_W bits: signed decimated sample at the FIFO head.
REQ-011 SHALL have port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data this cycle.
REQ-013 SHALL have port sat, output, 1 bit: sticky flag, set when any output sample was clipped.
REQ-014 SHALL have port ovf, output, 1 bit: sticky flag, set when a result was dropped because the FIFO was full.
REQ-015 SHALL have port clr_flags, input, 1 bit: synchronous clear of sat and ovf.

Function
REQ-016 SHALL keep a signed accumulator of IN_W+DECIM_LOG2 bits and a DECIM_LOG2-bit phase counter.
REQ-017 SHALL add sign-extended in_sum into the accumulator on each cycle where in_valid=1, and increment the phase counter.
REQ-018 SHALL, on the in_valid cycle where phase = 2^DECIM_LOG2-1, form the result from the accumulator plus the current input, reload the accumulator with 0, and wrap the phase to 0.
REQ-019 SHALL compute the result as follows, with S = DECIM_LOG2+OUT_SHIFT:
- If S>0, add 2^(S-1) and then arithmetic-shift right by S, i.e. round half-up.
- Saturate the shifted value to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-020 SHALL set sat on the cycle a clipped result is produced.
REQ-021 SHALL push the result into the FIFO one clock after the final input, giving a latency of 1 cycle from the last in_valid to the push and 2 cycles to out_valid when the FIFO was empty.
REQ-022 SHALL, when a push arrives while the FIFO is full and out_ready=0, drop the result, leave FIFO contents unchanged, and set ovf.
REQ-023 SHALL accept a push while the FIFO is full if a pop occurs in the same cycle (out_valid & out_ready).
REQ-024 SHALL pop on out_valid & out_ready; out_data SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-025 SHALL treat a pop on an empty FIFO as a no-op.
REQ-026 SHALL give priority to set when clr_flags and a set event occur in the same cycle, so the flag remains 1.
REQ-027 SHALL, when in_valid=0, hold the accumulator and phase; gaps between inputs do not affect the result.

Reset
REQ-028 SHALL, on rst=1, asynchronously clear the accumulator, phase, FIFO pointers and count, pending push, sat, and ovf.
REQ-029 SHALL drive out_valid=0 and out_data=0 during and after reset until the first push.
REQ-030 SHALL discard any partially accumulated group when reset is asserted mid-group; the next 2^DECIM_LOG2 inputs form a fresh group.

Structure
REQ-031 SHALL take the IN_W and OUT_W defaults and the saturation limit constants from the shared beamformer package, beam_pkg.
REQ-032 SHALL implement the output buffer as sub-module sync_fifo (parameters WIDTH and DEPTH; ports clk, rst, push, din, pop, dout, full, empty).
REQ-033 SHALL keep the accumulate, round and saturate logic in beam_decimator itself, with no further sub-modules.

Verification (all scenarios use default parameters)
REQ-034 SHALL cover basic rounding: 4 inputs of 1000 with out_ready=1 -> out_data=8, one out_valid pulse 2 cycles after the 4th input, sat=0.
REQ-035 SHALL cover positive saturation: 4 inputs of 4194303 -> out_data=32767, sat=1; then clr_flags -> sat=0.
REQ-036 SHALL cover the negative boundary: 4 inputs of -4194304 -> out_data=-32768, sat=0.
REQ-037 SHALL cover FIFO overflow: out_ready=0 with 20 inputs of 512 -> 4 samples of 4 held, ovf=1; then out_ready=1 -> exactly 4 pops of 4, then out_valid=0.
REQ-038 SHALL cover reset mid-group: 2 inputs of 10000, assert rst, then 4 inputs of 512 -> a single out_data=4, with no contribution from the 10000s.
REQ-039 SHALL cover input gaps and concurrent push/pop: in_valid asserted every 3rd cycle with random out_ready -> output stream matches the reference model, and no ovf is set while the FIFO is not full.
